// File: rtl/axi_multitimer.sv
//==============================================================================
// Module   : axi_multitimer
// Brief    : 64-bit mtime counter with prescaler/enable and NUM_CH compare
//            channels, each driving a registered level timer interrupt.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module axi_multitimer #(
  parameter int NUM_CH  = 1,
  parameter int PRESC_W = 8,
  parameter int AW      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [7:0]        i_be,
  input  logic [63:0]       i_wdata,
  output logic [63:0]       o_rdata,
  output logic [NUM_CH-1:0] o_timer_irq,
  output logic              o_tick
);

  localparam int unsigned c_W_MTIME    = 0;
  localparam int unsigned c_W_CTRL     = 1;
  localparam int unsigned c_W_STATUS   = 2;
  localparam int unsigned c_W_CMP_BASE = 4;

  logic [63:0]        mtime_q, mtime_d;
  logic [PRESC_W-1:0] pcnt_q, pcnt_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               en_q, en_d;
  logic [63:0]        cmp_q [NUM_CH];
  logic [63:0]        cmp_d [NUM_CH];
  logic [NUM_CH-1:0]  irq_q, irq_d;
  logic [63:0]        rdata_q, rdata_d;
  logic               tick_q, tick_d;

  logic [63:0]        w_be_mask;
  logic               w_wr;
  logic               w_rd;
  logic [AW-4:0]      w_word;
  int unsigned        w_word_idx;
  logic               w_inc;
  logic               w_wr_mtime;
  logic               w_wr_ctrl;
  logic [63:0]        w_ctrl_rd;
  logic [63:0]        w_status_rd;
  logic               w_unused_addr;

  assign w_word        = i_addr[AW-1:3];
  assign w_word_idx    = 32'(w_word);
  assign w_unused_addr = ^i_addr[2:0];
  // A write with no byte enabled is a no-op, including for pcnt clearing.
  assign w_wr          = i_req & i_we & (|i_be);
  assign w_rd          = i_req & ~i_we;
  assign w_wr_mtime    = w_wr && (w_word_idx == c_W_MTIME);
  assign w_wr_ctrl     = w_wr && (w_word_idx == c_W_CTRL);
  assign w_inc         = en_q && (pcnt_q == presc_q);

  always_comb begin
    w_be_mask = '0;
    for (int b = 0; b < 8; b++) begin
      w_be_mask[8*b +: 8] = {8{i_be[b]}};
    end
  end

  always_comb begin
    w_ctrl_rd                  = '0;
    w_ctrl_rd[0]               = en_q;
    w_ctrl_rd[8 +: PRESC_W]    = presc_q;
    w_status_rd                = '0;
    w_status_rd[NUM_CH-1:0]    = irq_q;
  end

  always_comb begin
    mtime_d = mtime_q;
    pcnt_d  = pcnt_q;
    en_d    = en_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    cmp_d   = cmp_q;

    if (en_q) begin
      if (w_inc) begin
        mtime_d = mtime_q + 64'd1;
        pcnt_d  = '0;
        tick_d  = 1'b1;
      end else begin
        pcnt_d  = pcnt_q + 1'b1;
      end
    end

    // A software write to mtime overrides (and swallows) a coincident tick.
    if (w_wr_mtime) begin
      mtime_d = (mtime_q & ~w_be_mask) | (i_wdata & w_be_mask);
      tick_d  = 1'b0;
    end

    if (w_wr_ctrl) begin
      if (i_be[0]) begin
        en_d = i_wdata[0];
      end
      presc_d = (presc_q & ~w_be_mask[8 +: PRESC_W]) |
                (i_wdata[8 +: PRESC_W] & w_be_mask[8 +: PRESC_W]);
      if (i_be[0] | i_be[1]) begin
        pcnt_d = '0;
      end
    end

    for (int i = 0; i < NUM_CH; i++) begin
      if (w_wr && (w_word_idx == c_W_CMP_BASE + i)) begin
        cmp_d[i] = (cmp_q[i] & ~w_be_mask) | (i_wdata & w_be_mask);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      irq_d[i] = (mtime_q >= cmp_q[i]);
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (w_rd) begin
      rdata_d = '0;
      if (w_word_idx == c_W_MTIME) begin
        rdata_d = mtime_q;
      end else if (w_word_idx == c_W_CTRL) begin
        rdata_d = w_ctrl_rd;
      end else if (w_word_idx == c_W_STATUS) begin
        rdata_d = w_status_rd;
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_word_idx == c_W_CMP_BASE + i) begin
          rdata_d = cmp_q[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_q <= '0;
      pcnt_q  <= '0;
      en_q    <= 1'b1;
      presc_q <= '0;
      irq_q   <= '0;
      rdata_q <= '0;
      tick_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        cmp_q[i] <= '1;
      end
    end else begin
      mtime_q <= mtime_d;
      pcnt_q  <= pcnt_d;
      en_q    <= en_d;
      presc_q <= presc_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
      tick_q  <= tick_d;
      for (int i = 0; i < NUM_CH; i++) begin
        cmp_q[i] <= cmp_d[i];
      end
    end
  end

  assign o_rdata     = rdata_q;
  assign o_timer_irq = irq_q;
  assign o_tick      = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_axi_multitimer.sv
//==============================================================================
// Module   : tb_axi_multitimer
// Brief    : Self-checking bench for axi_multitimer against a register-level
//            reference model; directed scenarios followed by random traffic.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_axi_multitimer;

  localparam int NUM_CH  = 4;
  localparam int PRESC_W = 8;
  localparam int AW      = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_req = 1'b0;
  logic              i_we = 1'b0;
  logic [AW-1:0]     i_addr = '0;
  logic [7:0]        i_be = '0;
  logic [63:0]       i_wdata = '0;
  logic [63:0]       o_rdata;
  logic [NUM_CH-1:0] o_timer_irq;
  logic              o_tick;

  axi_multitimer #(.NUM_CH(NUM_CH), .PRESC_W(PRESC_W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .i_req(i_req), .i_we(i_we), .i_addr(i_addr),
    .i_be(i_be), .i_wdata(i_wdata), .o_rdata(o_rdata),
    .o_timer_irq(o_timer_irq), .o_tick(o_tick)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Architectural state of the timer as software sees it.
  logic [63:0]       m_mtime;
  logic [63:0]       m_cmp [NUM_CH];
  logic [63:0]       m_rdata;
  int                m_pcnt;
  int                m_presc;
  bit                m_en;
  logic [NUM_CH-1:0] m_irq;
  bit                m_tick;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old_v, input logic [63:0] new_v,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old_v;
    for (int b = 0; b < 8; b++) if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [63:0] ctrl_val();
    return (64'(m_presc) << 8) | 64'(m_en);
  endfunction

  function automatic logic [63:0] mread(input int w);
    if (w == 0) return m_mtime;
    if (w == 1) return ctrl_val();
    if (w == 2) return 64'(m_irq);
    if (w >= 4 && w < 4 + NUM_CH) return m_cmp[w-4];
    return 64'd0;
  endfunction

  task automatic model_reset();
    m_mtime = 0; m_pcnt = 0; m_presc = 0; m_en = 1'b1;
    m_irq = '0; m_rdata = 0; m_tick = 1'b0;
    for (int i = 0; i < NUM_CH; i++) m_cmp[i] = '1;
  endtask

  // One clock cycle: present an access, advance the model, compare outputs.
  task automatic step(input bit req, input bit we, input logic [AW-1:0] a,
                      input logic [7:0] be, input logic [63:0] wd);
    int w, npc, npr;
    bit nen, ntk;
    logic [63:0] nt, nrd, c;
    logic [63:0] ncmp [NUM_CH];
    logic [NUM_CH-1:0] nirq;
    i_req = req; i_we = we; i_addr = a; i_be = be; i_wdata = wd;
    w = int'(a >> 3);
    nt = m_mtime; npc = m_pcnt; nen = m_en; npr = m_presc; ntk = 1'b0;
    ncmp = m_cmp; nrd = m_rdata;
    if (m_en) begin
      if (m_pcnt == m_presc) begin nt = m_mtime + 64'd1; npc = 0; ntk = 1'b1; end
      else npc = m_pcnt + 1;
    end
    if (req && we && be != 8'h00) begin
      if (w == 0) begin
        nt = merge(m_mtime, wd, be); ntk = 1'b0;
      end else if (w == 1) begin
        c = merge(ctrl_val(), wd, be);
        nen = c[0]; npr = int'(c[15:8]);
        if (be[0] | be[1]) npc = 0;
      end else if (w >= 4 && w < 4 + NUM_CH) begin
        ncmp[w-4] = merge(m_cmp[w-4], wd, be);
      end
    end
    if (req && !we) nrd = mread(w);
    for (int i = 0; i < NUM_CH; i++) nirq[i] = (m_mtime >= m_cmp[i]);
    @(posedge clk);
    #1;
    m_mtime = nt; m_pcnt = npc; m_en = nen; m_presc = npr; m_tick = ntk;
    m_cmp = ncmp; m_rdata = nrd; m_irq = nirq;
    i_req = 1'b0; i_we = 1'b0; i_be = '0;
    check("rdata", o_rdata, m_rdata);
    check("irq", 64'(o_timer_irq), 64'(m_irq));
    check("tick", 64'(o_tick), 64'(m_tick));
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(1'b1, 1'b0, a, 8'h00, 64'd0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [7:0] be, input logic [63:0] d);
    step(1'b1, 1'b1, a, be, d);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [63:0]   rd_v;
    int            sel;
    model_reset();
    // Reset held for three cycles, outputs at reset values.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdata", o_rdata, 64'd0);
    check("rst_irq", 64'(o_timer_irq), 64'd0);
    check("rst_tick", 64'(o_tick), 64'd0);
    rst = 1'b0;

    // mtime counts 1,2,3... with back-to-back reads, CTRL defaults to EN=1.
    repeat (6) rd(8'h00);
    rd(8'h08);
    check("ctrl_default", o_rdata, 64'h1);
    repeat (1000) rd(8'h00);

    // Prescaler of 3, then disable.
    wr(8'h08, 8'hFF, 64'h0301);
    repeat (40) rd(8'h00);
    wr(8'h08, 8'hFF, 64'h0000);
    repeat (50) rd(8'h00);

    // Compare on channel 2.
    wr(8'h08, 8'hFF, 64'h0001);
    wr(8'h00, 8'hFF, 64'd0);
    wr(8'h30, 8'hFF, 64'd100);
    repeat (110) rd(8'h10);
    check("status_ch2", o_rdata, 64'h4);
    wr(8'h30, 8'hFF, '1);
    repeat (3) rd(8'h10);

    // Partial byte write to a running mtime.
    wr(8'h00, 8'hFF, 64'hA5A5_0000_0000_0000);
    wr(8'h00, 8'h0F, 64'h0000_0000_1234_5678);
    repeat (3) rd(8'h00);
    wr(8'h00, 8'h00, 64'hDEAD_BEEF_DEAD_BEEF);
    rd(8'h00);

    // Wrap past 2^64-1 with a low compare on channel 0.
    wr(8'h20, 8'hFF, 64'd2);
    wr(8'h00, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE);
    repeat (8) rd(8'h00);
    repeat (4) rd(8'h10);

    // Unmapped addresses.
    rd(8'h18);
    check("unmapped_18", o_rdata, 64'd0);
    rd(8'h40);
    check("unmapped_40", o_rdata, 64'd0);
    wr(8'h18, 8'hFF, 64'h1234);
    wr(8'h40, 8'hFF, 64'h5678);
    wr(8'hF8, 8'hFF, 64'h9ABC);
    rd(8'h18);
    rd(8'h40);

    // Randomised traffic with small prescalers and compare values near mtime.
    wr(8'h00, 8'hFF, 64'd0);
    for (int n = 0; n < 600; n++) begin
      sel = int'($urandom_range(0, 9));
      ra = AW'(sel * 8) | AW'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) begin
        if (sel == 1) rd_v = (64'($urandom_range(0, 3)) << 8) | 64'($urandom_range(0, 4) != 0);
        else if (sel == 0) rd_v = 64'($urandom_range(0, 300));
        else rd_v = {32'($urandom), 32'($urandom)} >> $urandom_range(50, 63);
        wr(ra, 8'($urandom), rd_v);
      end else if ($urandom_range(0, 3) == 0) begin
        step(1'b0, 1'b0, ra, 8'($urandom), 64'd0);
      end else begin
        rd(ra);
      end
    end

    // Asynchronous reset pulse while counting with an interrupt active.
    wr(8'h08, 8'hFF, 64'h0001);
    wr(8'h28, 8'hFF, 64'd0);
    repeat (3) rd(8'h00);
    rst = 1'b1;
    #1;
    check("async_rdata", o_rdata, 64'd0);
    check("async_irq", 64'(o_timer_irq), 64'd0);
    check("async_tick", 64'(o_tick), 64'd0);
    #2;
    rst = 1'b0;
    model_reset();
    repeat (4) rd(8'h00);
    rd(8'h28);
    check("cmp_after_rst", o_rdata, '1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
